// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {inst, pc} with flush.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              inst_in,
  input  logic [31:0]              pc_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = !flush && (!empty || byp);
  // A bypassed entry consumed in the same cycle never touches storage.
  assign pop       = !empty && out_valid && out_ready;
  assign push      = in_valid && in_ready && !flush && !(byp && out_ready);

  // Head selection; NOP and zero PC whenever nothing is valid.
  always_comb begin
    out_inst = NOP_INST;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = inst_mem[rd_ptr];
      out_pc   = pc_mem[rd_ptr];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (byp) begin
      out_inst = inst_in;
      out_pc   = pc_in;
    end
`endif
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[wr_ptr] <= inst_in;
      pc_mem[wr_ptr]   <= pc_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_in   (inst_in),
    .pc_in     (pc_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mq [$];
  logic [31:0] got_pc [$];
  logic        s_valid;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic        s_ready;
  logic [31:0] s_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    int          sz;
    logic        byp;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    in_valid  = iv;
    inst_in   = ins;
    pc_in     = p;
    out_ready = ordy;
    flush     = fl;
    #3;
    sz  = mq.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && iv && !fl;
`endif
    ev = !fl && (sz > 0 || byp);
    ei = NOP;
    ep = 32'h0;
    if (ev) begin
      if (sz > 0) {ei, ep} = mq[0];
      else begin
        ei = ins;
        ep = p;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_inst", out_inst, ei);
    chk("out_pc", out_pc, ep);
    chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
    chk("count", 32'(count), 32'(sz));
    s_valid = out_valid;
    s_inst  = out_inst;
    s_pc    = out_pc;
    s_ready = in_ready;
    s_count = 32'(count);
    if (out_valid && ordy) got_pc.push_back(out_pc);
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (ev && ordy && sz > 0) void'(mq.pop_front());
      if (iv && sz < DEPTH && !(byp && ordy)) mq.push_back({ins, p});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst_in = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();

    // Post-reset idle state
    idle(1'b0);
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_inst", s_inst, 32'h00000013);
    chk("rst_ready", 32'(s_ready), 32'h1);
    chk("rst_count", s_count, 32'h0);

    // Fill to capacity, fifth push refused, then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00500093 + 32'(i) * 32'h00100000, 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h00900093, 32'h10, 1'b0, 1'b0);
    chk("full_count", s_count, 32'h4);
    chk("full_ready", 32'(s_ready), 32'h0);
    idle(1'b0);
    chk("fifth_refused", s_count, 32'h4);
    chk("head_inst", s_inst, 32'h00500093);
    got_pc.delete();
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    chk("drain_count", s_count, 32'h0);
    chk("drain_len", 32'(got_pc.size()), 32'h4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) chk("drain_pc", got_pc[i], 32'(i * 4));

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00100113 + 32'(i), 32'h20 + 32'(i * 4), 1'b0, 1'b0);
    got_pc.delete();
    step(1'b1, 32'h00B00093, 32'h30, 1'b1, 1'b0);
    chk("fullpp_ready", 32'(s_ready), 32'h0);
    idle(1'b0);
    chk("fullpp_count", s_count, 32'h3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("fullpp_len", 32'(got_pc.size()), 32'h4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) chk("fullpp_pc", got_pc[i], 32'h20 + 32'(i * 4));

    // Six through with out_ready held high: pointer wrap, no gaps
    got_pc.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h00200193 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("wrap_len", 32'(got_pc.size()), 32'h6);
    for (int i = 0; i < 6 && i < got_pc.size(); i++) chk("wrap_pc", got_pc[i], 32'(i * 4));

    // Flush with three queued and an incoming instruction
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00300213 + 32'(i), 32'h40 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 32'h50, 1'b1, 1'b1);
    chk("flush_valid", 32'(s_valid), 32'h0);
    chk("flush_inst", s_inst, 32'h00000013);
    idle(1'b1);
    chk("flush_count", s_count, 32'h0);
    chk("flush_after_valid", 32'(s_valid), 32'h0);

    // Empty queue, push with out_ready high
    step(1'b1, 32'hFF010113, 32'h100, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(s_valid), 32'h1);
    chk("byp_inst", s_inst, 32'hFF010113);
    chk("byp_pc", s_pc, 32'h100);
    idle(1'b1);
    chk("byp_count", s_count, 32'h0);
`else
    chk("nobyp_valid", 32'(s_valid), 32'h0);
    idle(1'b1);
    chk("nobyp_next_valid", 32'(s_valid), 32'h1);
    chk("nobyp_next_inst", s_inst, 32'hFF010113);
    chk("nobyp_next_pc", s_pc, 32'h100);
    idle(1'b0);
    chk("nobyp_count", s_count, 32'h0);
`endif

    // Mixed traffic pattern with a mid-stream flush
    for (int i = 0; i < 24; i++)
      step(1'((i % 3) != 0), 32'h00400293 + 32'(i), 32'h200 + 32'(i * 4), 1'((i % 4) == 3), 1'(i == 13));

    // Reset mid-stream takes priority over a push
    step(1'b1, 32'h00600313, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 32'h304, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; inst_in = 32'h00800413; pc_in = 32'h308; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    idle(1'b0);
    chk("mid_rst_count", s_count, 32'h0);
    chk("mid_rst_valid", 32'(s_valid), 32'h0);
    chk("mid_rst_ready", 32'(s_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
